// File: rtl/cluster_soc_evt_bridge_if.sv
// rtl/cluster_soc_evt_bridge_if.sv - cluster-to-SoC event bridge signal bundle
interface cluster_soc_evt_bridge_if #(
    parameter int N_SRC     = 3,
    parameter int CNT_WIDTH = 4
);
    logic [N_SRC-1:0]           evt_pulse_i;
    logic [N_SRC-1:0]           evt_valid_o;
    logic [N_SRC-1:0]           evt_ack_i;
    logic [N_SRC*CNT_WIDTH-1:0] pending_o;
    logic [N_SRC-1:0]           overflow_o;
    logic                       clr_overflow_i;
    logic                       busy_o;

    modport master (
        input  evt_pulse_i,
        input  evt_ack_i,
        input  clr_overflow_i,
        output evt_valid_o,
        output pending_o,
        output overflow_o,
        output busy_o
    );

    modport slave (
        output evt_pulse_i,
        output evt_ack_i,
        output clr_overflow_i,
        input  evt_valid_o,
        input  pending_o,
        input  overflow_o,
        input  busy_o
    );
endinterface

// File: rtl/cluster_soc_evt_bridge.sv
// rtl/cluster_soc_evt_bridge.sv - per-source event counters driving four-phase valid/ack toward the SoC
module cluster_soc_evt_bridge #(
    parameter int N_SRC     = 3,
    parameter int CNT_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cluster_soc_evt_bridge_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e               state_q [N_SRC];
    state_e               state_d [N_SRC];
    logic [CNT_WIDTH-1:0] cnt_q   [N_SRC];
    logic [CNT_WIDTH-1:0] cnt_d   [N_SRC];
    logic [N_SRC-1:0]     valid_q;
    logic [N_SRC-1:0]     valid_d;
    logic [N_SRC-1:0]     ovf_q;
    logic [N_SRC-1:0]     ovf_d;
    logic [N_SRC-1:0]     ovf_set;
    logic                 busy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Issuing from IDLE consumes one event while a same-edge pulse adds one,
    // so that path can never exceed CNT_MAX; only busy states can saturate.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            ovf_set[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if ((cnt_q[i] != CNT_ZERO) || bus.evt_pulse_i[i]) begin
                        state_d[i] = REQ;
                        if (!bus.evt_pulse_i[i]) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                end
                REQ, WAIT_LOW: begin
                    if (bus.evt_pulse_i[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_set[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    if ((state_q[i] == REQ) && bus.evt_ack_i[i]) begin
                        state_d[i] = WAIT_LOW;
                    end else if ((state_q[i] == WAIT_LOW) && !bus.evt_ack_i[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
            valid_d[i] = (state_d[i] == REQ);
            // A drop on the same edge as a clear must remain visible.
            ovf_d[i]   = ovf_set[i] | (ovf_q[i] & ~bus.clr_overflow_i);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if ((state_q[i] != IDLE) || (cnt_q[i] != CNT_ZERO)) begin
                busy = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_pending
        assign bus.pending_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    assign bus.evt_valid_o = valid_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.busy_o      = busy;
endmodule

// File: tb/tb_cluster_soc_evt_bridge.sv
// tb/tb_cluster_soc_evt_bridge.sv - scoreboard bench for cluster_soc_evt_bridge
module tb_cluster_soc_evt_bridge;
    localparam int N   = 3;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cluster_soc_evt_bridge_if #(.N_SRC(N), .CNT_WIDTH(W)) bus ();
    cluster_soc_evt_bridge #(.N_SRC(N), .CNT_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: backlog of events not yet issued, plus whether a
    // handshake is in flight and whether its ack has been seen.
    int m_backlog [N];
    bit m_txn     [N];
    bit m_acked   [N];
    bit m_ovf     [N];
    int exp_q     [N][$];
    int txn_cnt   [N];

    bit stall  [N];
    bit manual [N];
    bit tie    [N];
    int dly    [N];
    int hold   [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_backlog[c] = 0;
            m_txn[c]     = 1'b0;
            m_acked[c]   = 1'b0;
            m_ovf[c]     = 1'b0;
            exp_q[c].delete();
        end
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] a, input logic clr);
        for (int c = 0; c < N; c++) begin
            bit set;
            int tot;
            set = 1'b0;
            if (!m_txn[c]) begin
                tot = m_backlog[c] + int'(p[c]);
                if (tot > 0) begin
                    m_txn[c]     = 1'b1;
                    m_acked[c]   = 1'b0;
                    m_backlog[c] = tot - 1;
                    exp_q[c].push_back(cyc);
                end
            end else begin
                if (p[c]) begin
                    if (m_backlog[c] + 1 > MAX) set = 1'b1;
                    else m_backlog[c] = m_backlog[c] + 1;
                end
                if (!m_acked[c] && a[c]) m_acked[c] = 1'b1;
                else if (m_acked[c] && !a[c]) m_txn[c] = 1'b0;
            end
            m_ovf[c] = set ? 1'b1 : (clr ? 1'b0 : m_ovf[c]);
        end
    endtask

    task automatic check_outputs();
        bit busy_exp;
        busy_exp = 1'b0;
        for (int c = 0; c < N; c++) begin
            check($sformatf("pending%0d", c), 32'(bus.pending_o[c*W +: W]), 32'(m_backlog[c]));
            check($sformatf("overflow%0d", c), 32'(bus.overflow_o[c]), 32'(m_ovf[c]));
            check($sformatf("valid%0d", c), 32'(bus.evt_valid_o[c]), 32'(m_txn[c] && !m_acked[c]));
            if (m_txn[c] || (m_backlog[c] != 0)) busy_exp = 1'b1;
        end
        check("busy", 32'(bus.busy_o), 32'(busy_exp));
    endtask

    task automatic soc_update();
        for (int c = 0; c < N; c++) begin
            if (tie[c]) begin
                bus.evt_ack_i[c] = bus.evt_valid_o[c];
            end else if (!manual[c]) begin
                if (stall[c]) begin
                    bus.evt_ack_i[c] = 1'b0;
                end else if (!bus.evt_ack_i[c]) begin
                    if (bus.evt_valid_o[c]) begin
                        if (dly[c] == 0) bus.evt_ack_i[c] = 1'b1;
                        else dly[c] = dly[c] - 1;
                    end else begin
                        dly[c] = $urandom_range(0, 2);
                    end
                end else begin
                    if (!bus.evt_valid_o[c]) begin
                        if (hold[c] == 0) bus.evt_ack_i[c] = 1'b0;
                        else hold[c] = hold[c] - 1;
                    end else begin
                        hold[c] = $urandom_range(0, 2);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) model_step(bus.evt_pulse_i, bus.evt_ack_i, bus.clr_overflow_i);
        @(negedge clk);
        check_outputs();
        soc_update();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [N-1:0] prev_v = '0;
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (!rst && bus.evt_valid_o[c] && !prev_v[c]) begin
                int e;
                txn_cnt[c] = txn_cnt[c] + 1;
                tests++;
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL txn%0d: unexpected valid rise at cycle %0d, none expected", c, cyc);
                end else begin
                    e = exp_q[c].pop_front();
                    if (e != cyc) begin
                        fails++;
                        $display("FAIL txn%0d: valid rose at cycle %0d expected %0d", c, cyc, e);
                    end
                end
            end
        end
        prev_v = bus.evt_valid_o;
    end

    int base;

    initial begin
        bus.evt_pulse_i    = '0;
        bus.evt_ack_i      = '0;
        bus.clr_overflow_i = 1'b0;
        for (int c = 0; c < N; c++) begin
            stall[c] = 0; manual[c] = 0; tie[c] = 0; dly[c] = 0; hold[c] = 0; txn_cnt[c] = 0;
        end
        model_reset();

        ticks(2);
        rst = 1'b0;
        ticks(2);

        // single event on ch0
        bus.evt_pulse_i[0] = 1'b1;
        tick();
        bus.evt_pulse_i[0] = 1'b0;
        check("single_valid", 32'(bus.evt_valid_o[0]), 32'd1);
        ticks(10);
        check("single_pending", 32'(bus.pending_o[0 +: W]), 32'd0);
        check("single_busy", 32'(bus.busy_o), 32'd0);

        // pulse landing on an IDLE->REQ issue with one event backlogged
        manual[0] = 1; bus.evt_ack_i[0] = 1'b0;
        bus.evt_pulse_i[0] = 1'b1; ticks(2);
        bus.evt_pulse_i[0] = 1'b0; bus.evt_ack_i[0] = 1'b1; tick();
        bus.evt_ack_i[0] = 1'b0; tick();
        check("issue_pre", 32'(bus.pending_o[0 +: W]), 32'd1);
        bus.evt_pulse_i[0] = 1'b1; tick();
        bus.evt_pulse_i[0] = 1'b0;
        check("pulse_with_issue", 32'(bus.pending_o[0 +: W]), 32'd1);
        manual[0] = 0;
        ticks(20);

        // burst on ch1 with ack tied to valid
        base = txn_cnt[1];
        tie[1] = 1;
        bus.evt_pulse_i[1] = 1'b1; ticks(5);
        bus.evt_pulse_i[1] = 1'b0; ticks(20);
        tie[1] = 0;
        check("burst_txns", 32'(txn_cnt[1] - base), 32'd5);
        check("burst_end_pending", 32'(bus.pending_o[W +: W]), 32'd0);
        check("burst_ovf", 32'(bus.overflow_o[1]), 32'd0);

        // saturation on ch2 with ack held low
        base = txn_cnt[2];
        stall[2] = 1;
        bus.evt_pulse_i[2] = 1'b1; ticks(20);
        bus.evt_pulse_i[2] = 1'b0;
        check("ovf_pending", 32'(bus.pending_o[2*W +: W]), 32'(MAX));
        check("ovf_flag", 32'(bus.overflow_o[2]), 32'd1);
        check("ovf_one_txn", 32'(txn_cnt[2] - base), 32'd1);
        bus.evt_pulse_i[2] = 1'b1; bus.clr_overflow_i = 1'b1; tick();
        bus.evt_pulse_i[2] = 1'b0; bus.clr_overflow_i = 1'b0;
        check("ovf_set_wins", 32'(bus.overflow_o[2]), 32'd1);
        tick();
        bus.clr_overflow_i = 1'b1; tick();
        bus.clr_overflow_i = 1'b0;
        check("ovf_cleared", 32'(bus.overflow_o[2]), 32'd0);
        stall[2] = 0;
        ticks(150);
        check("ovf_total_txns", 32'(txn_cnt[2] - base), 32'd16);

        // randomized traffic, responsive SoC
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) bus.evt_pulse_i[c] = ($urandom_range(0, 2) == 0);
            bus.clr_overflow_i = ($urandom_range(0, 19) == 0);
            tick();
        end
        // randomized traffic with SoC stalls to provoke saturation
        for (int i = 0; i < 600; i++) begin
            if ((i % 30) == 0) for (int c = 0; c < N; c++) stall[c] = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < N; c++) bus.evt_pulse_i[c] = ($urandom_range(0, 1) == 1);
            bus.clr_overflow_i = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.evt_pulse_i = '0; bus.clr_overflow_i = 1'b0;
        for (int c = 0; c < N; c++) stall[c] = 0;
        ticks(250);
        check("drain_busy", 32'(bus.busy_o), 32'd0);
        for (int c = 0; c < N; c++) check($sformatf("drain_queue%0d", c), 32'(exp_q[c].size()), 32'd0);

        // reset in the middle of a transaction
        stall[0] = 1;
        bus.evt_pulse_i[0] = 1'b1; ticks(4);
        bus.evt_pulse_i[0] = 1'b0;
        check("rst_pre_pending", 32'(bus.pending_o[0 +: W]), 32'd3);
        check("rst_pre_valid", 32'(bus.evt_valid_o[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(bus.evt_valid_o[0]), 32'd0);
        check("rst_async_pending", 32'(bus.pending_o[0 +: W]), 32'd0);
        model_reset();
        base = txn_cnt[0];
        stall[0] = 0;
        ticks(2);
        rst = 1'b0;
        ticks(12);
        check("rst_no_txn", 32'(txn_cnt[0] - base), 32'd0);
        check("rst_post_pending", 32'(bus.pending_o[0 +: W]), 32'd0);

        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
